// File: rtl/imem_line_responder.sv
// imem_line_responder: instruction-memory responder for the fetch stage.
// It keeps a single 4-word line buffer in front of a word-addressed backing
// array. Read hits and all writes complete in the request cycle. A read miss
// stalls for MISS_LAT wait cycles, fills the line over four cycles, and then
// answers in a RESP cycle.
// Optional feature macro: IMEM_LINE_RESPONDER_ERR_CHECK_EN. When it is defined,
// the block flags Rd+Wr collisions, misaligned accesses and X/Z inputs on err.
module imem_line_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int MISS_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  word_q, word_d;
    logic [15:1] cap_q, cap_d;
    logic        valid_q, valid_d;
    logic [12:0] tag_q, tag_d;

    logic [15:0] mem [MEM_WORDS];
    logic [15:0] line_q [4];

    logic        idle_w;
    logic        hit_w;
    logic        rd_go;
    logic        wr_go;
    logic        err_w;
    logic [15:1] fill_addr;

    // The dump file is produced by the simulation harness; in hardware the pin has no effect.
    logic unused_createdump;
    assign unused_createdump = createdump;

    assign idle_w    = rst_n && (state_q == S_IDLE);
    assign hit_w     = valid_q && (tag_q == Addr[15:3]);
    assign fill_addr = {cap_q[15:3], word_q};

`ifdef IMEM_LINE_RESPONDER_ERR_CHECK_EN
    logic x_in_w;
    assign x_in_w = ((^{Addr, Rd, Wr, DataIn}) === 1'bx);
    assign err_w  = idle_w && (x_in_w || (Rd && Wr) || ((Rd || Wr) && Addr[0]));
    assign rd_go  = idle_w && Rd && !err_w;
    assign wr_go  = idle_w && Wr && !err_w;
`else
    // Without checking, a collision is serviced as a read and Addr[0] is ignored.
    logic unused_addr0;
    assign unused_addr0 = Addr[0];
    assign err_w = 1'b0;
    assign rd_go = idle_w && Rd;
    assign wr_go = idle_w && Wr && !Rd;
`endif

    // Handshake outputs: hits and writes answer combinationally; misses answer from RESP.
    always_comb begin
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        DataOut  = '0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    err = err_w;
                    if (rd_go) begin
                        if (hit_w) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = line_q[Addr[2:1]];
                        end else begin
                            Stall = 1'b1;
                        end
                    end else if (wr_go) begin
                        Done     = 1'b1;
                        CacheHit = hit_w;
                    end
                end
                S_WAIT, S_FILL: Stall = 1'b1;
                S_RESP: begin
                    Done    = 1'b1;
                    DataOut = line_q[cap_q[2:1]];
                end
                default: ;
            endcase
        end
    end

    // Next-state logic of the miss sequencer and line tag/valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (rd_go && !hit_w) begin
                    cap_d   = Addr[15:1];
                    cnt_d   = 4'(MISS_LAT - 1);
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    word_d  = 2'd0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_FILL: begin
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) begin
                    valid_d = 1'b1;
                    tag_d   = cap_q[15:3];
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; an asynchronous reset aborts any miss in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    // Backing array and line data: no reset, write-through on hit, one word per FILL cycle.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[Addr[IW:1]] <= DataIn;
            if (hit_w) begin
                line_q[Addr[2:1]] <= DataIn;
            end
        end
        if (state_q == S_FILL) begin
            line_q[word_q] <= mem[fill_addr[IW:1]];
        end
    end
endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder. Two instances share their inputs:
// dut0 uses MISS_LAT=4 and dut1 uses MISS_LAT=1. Expected results are queued
// when a request is driven and are compared when the selected DUT raises Done.
module tb_imem_line_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic        createdump = 1'b0;

    logic [15:0] dout0, dout1;
    logic        done0, done1, stall0, stall1, hit0, hit1, err0, err1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        logic        hit;
        int          lat;
        logic        is_rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    imem_line_responder #(.MEM_WORDS(1024), .MISS_LAT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .createdump(createdump), .DataOut(dout0), .Done(done0), .Stall(stall0),
        .CacheHit(hit0), .err(err0)
    );

    imem_line_responder #(.MEM_WORDS(1024), .MISS_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .createdump(createdump), .DataOut(dout1), .Done(done1), .Stall(stall1),
        .CacheHit(hit1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one request just after a clock edge and follows it to Done.
    task automatic do_req(input int sel, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic ehit, input logic [15:0] edata,
                          input int elat, input string tag);
        exp_t        e;
        exp_t        got;
        int          cyc;
        bit          fin;
        logic        dn, st, ht, er;
        logic [15:0] dq;
        e.data = edata; e.hit = ehit; e.lat = elat; e.is_rd = rd;
        sb.push_back(e);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            dn = (sel == 1) ? done1  : done0;
            st = (sel == 1) ? stall1 : stall0;
            ht = (sel == 1) ? hit1   : hit0;
            er = (sel == 1) ? err1   : err0;
            dq = (sel == 1) ? dout1  : dout0;
            if (dn) begin
                got = sb.pop_front();
                chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
                chk({tag, " cachehit"}, {31'd0, ht}, {31'd0, got.hit});
                chk({tag, " err"}, {31'd0, er}, 32'd0);
                chk({tag, " stall_with_done"}, {31'd0, st}, 32'd0);
                if (got.is_rd) chk({tag, " data"}, {16'd0, dq}, {16'd0, got.data});
                $display("txn %s dut%0d rd=%0b wr=%0b addr=%h din=%h dout=%h hit=%0b lat=%0d",
                         tag, sel, rd, wr, a, d, dq, ht, cyc);
                fin = 1'b1;
            end else begin
                chk({tag, " stall"}, {31'd0, st}, 32'd1);
                if (cyc >= elat + 20) begin
                    chk({tag, " timeout"}, 32'(cyc), 32'(elat));
                    void'(sb.pop_front());
                    fin = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
            end
        end
        @(posedge clk);
        #1;
        Rd = 1'b0;
        Wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        chk("reset done", {31'd0, done0}, 32'd0);
        chk("reset stall", {31'd0, stall0}, 32'd0);
        chk("reset cachehit", {31'd0, hit0}, 32'd0);
        chk("reset err", {31'd0, err0}, 32'd0);
        chk("reset dataout", {16'd0, dout0}, 32'd0);
        $display("txn reset checked");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload the backing array through miss writes (no allocate).
        do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 0, "wr_0010");
        do_req(0, 1'b0, 1'b1, 16'h0012, 16'h1234, 1'b0, 16'h0000, 0, "wr_0012");
        do_req(0, 1'b0, 1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0000, 0, "wr_0040");
        do_req(0, 1'b0, 1'b1, 16'h0200, 16'hCAFE, 1'b0, 16'h0000, 0, "wr_0200");

        // Miss, then back-to-back hit on the same line.
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 9, "rd_miss_0010");
        do_req(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'h1234, 0, "rd_hit_0012");

        // Write hit updates the buffered line; write miss does not allocate.
        do_req(0, 1'b0, 1'b1, 16'h0014, 16'hA5A5, 1'b1, 16'h0000, 0, "wr_hit_0014");
        do_req(0, 1'b1, 1'b0, 16'h0014, 16'h0000, 1'b1, 16'hA5A5, 0, "rd_hit_0014");
        do_req(0, 1'b0, 1'b1, 16'h0100, 16'h1111, 1'b0, 16'h0000, 0, "wr_miss_0100");
        do_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h1111, 9, "rd_miss_0100");
        do_req(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'h1234, 9, "rd_remiss_0012");

        // Reset in the middle of a miss.
        Rd = 1'b1; Addr = 16'h0040;
        @(negedge clk);
        chk("midmiss stall", {31'd0, stall0}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midmiss rst done", {31'd0, done0}, 32'd0);
        chk("midmiss rst stall", {31'd0, stall0}, 32'd0);
        chk("midmiss rst cachehit", {31'd0, hit0}, 32'd0);
        chk("midmiss rst err", {31'd0, err0}, 32'd0);
        chk("midmiss rst dataout", {16'd0, dout0}, 32'd0);
        $display("txn reset asserted mid-miss at cycle 3");
        @(negedge clk);
        Rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h7777, 9, "rd_after_rst_0040");
        do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777, 0, "rd_hit_0040");

`ifdef IMEM_LINE_RESPONDER_ERR_CHECK_EN
        // Collision: flagged, not performed.
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hDEAD;
        @(negedge clk);
        chk("collide err", {31'd0, err0}, 32'd1);
        chk("collide done", {31'd0, done0}, 32'd0);
        chk("collide stall", {31'd0, stall0}, 32'd0);
        $display("txn collide addr=0040 err=%0b", err0);
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777, 0, "rd_after_collide");
        // Misaligned read: flagged, no fill started.
        Rd = 1'b1; Addr = 16'h0011;
        @(negedge clk);
        chk("misalign err", {31'd0, err0}, 32'd1);
        chk("misalign stall", {31'd0, stall0}, 32'd0);
        @(posedge clk);
        #1;
        Rd = 1'b0;
        @(negedge clk);
        chk("misalign no fill", {31'd0, stall0}, 32'd0);
        $display("txn misaligned addr=0011 rejected");
        @(posedge clk);
        #1;
`else
        // Collision is serviced as a read and the write is dropped.
        do_req(0, 1'b1, 1'b1, 16'h0040, 16'hDEAD, 1'b1, 16'h7777, 0, "collide_as_read");
        do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777, 0, "rd_after_collide");
`endif

        // Address wrap and aliasing of index bits above the array size.
        do_req(0, 1'b0, 1'b1, 16'hFFFE, 16'h4242, 1'b0, 16'h0000, 0, "wr_fffe");
        do_req(0, 1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h4242, 9, "rd_alias_07fe");
        do_req(0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h4242, 9, "rd_miss_fffe");
`ifndef IMEM_LINE_RESPONDER_ERR_CHECK_EN
        do_req(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h4242, 0, "rd_odd_ffff");
`endif

        // MISS_LAT=1 instance: Done six cycles after accept, then a back-to-back hit.
        do_req(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'hCAFE, 6, "lat1_miss_0200");
        do_req(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'hCAFE, 0, "lat1_hit_0200");

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Responder side of the fetch-to-memory request interface: it accepts single-word reads and writes from the fetch stage and answers with the usual Done/Stall/CacheHit/err signals. It holds a one-line (4-word) buffer in front of a word-addressed backing array. A buffer hit completes in the request cycle. A miss runs a multi-cycle fill FSM that emulates backing-memory latency. The block sits where the fetch stage's instruction memory system is instantiated and can replace that memory system in unit-level and stall-stress simulation.

## Interface
- MEM_WORDS, 1024: backing array depth in 16-bit words (power of 2, ≤ 32768); index = Addr[log2(MEM_WORDS):1].
- MISS_LAT, 4: wait cycles before the first fill word (1..15).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Addr  in  16  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request (level, sampled in IDLE).
- Wr  in  1  write request (level, sampled in IDLE).
- createdump  in  1  sim-only; when high at a clock edge, the array is written to the dump file once.
- DataOut  out  16  read data; valid only when Done=1.
- Done  out  1  request complete this cycle.
- Stall  out  1  busy; inputs ignored.
- CacheHit  out  1  qualifies Done: request served from the line buffer.
- err  out  1  protocol error this cycle.

## Operation
- Line buffer:
  - 4 words plus tag (Addr[15:3]) and valid bit.
  - Word select = Addr[2:1].
  - Array contents are not reset.
- FSM states: IDLE, WAIT, FILL, RESP.
- IDLE, read hit (Rd, valid, tag match):
  - Done=1, CacheHit=1, DataOut=buffer word, all combinational.
  - Remain in IDLE.
- IDLE, read miss:
  - Capture Addr, Stall=1 combinationally, go to WAIT.
  - Counter loads MISS_LAT-1.
- WAIT: Stall=1; decrement; at 0 go to FILL with word counter 0.
- FILL:
  - Stall=1.
  - Each cycle: buffer[k] ← array[{captured tag, k}], k = 0..3.
  - After k=3: set valid, load tag, go to RESP.
- RESP:
  - Stall=0, Done=1, CacheHit=0, DataOut=buffer[captured Addr[2:1]].
  - Next state IDLE.
  - Inputs in this cycle are ignored; a new request is accepted the next cycle.
- IDLE, write:
  - Array word written at the edge.
  - If tag matches a valid buffer, that buffer word is updated too; CacheHit=1, else 0.
  - No allocate on miss.
  - Done=1 in the same cycle.
- Rd and Wr both high in IDLE: err=1, no state change, no write, Done=0.
- Neither Rd nor Wr: all outputs 0 except DataOut (don't-care).

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE, valid=0, counters 0.
  - Done=0, Stall=0, CacheHit=0, err=0, DataOut=0.
- Reset asserted mid-miss aborts the miss: no Done, buffer invalid.
- Hit/write latency: 0 cycles (Done in the request cycle).
- Miss accepted at cycle T:
  - Stall=1 during T..T+MISS_LAT+4.
  - Done at T+MISS_LAT+5.
  - Default: Stall T..T+8, Done T+9.
- Stall and Done are never high together.
- Requester holds Addr stable while Stall=1; the block uses the captured copy regardless.
- A write to the line being filled is impossible, because requests are ignored while Stall=1.
- Address wrap: Addr FFFE maps to tag 1FFF, word 3; index bits above log2(MEM_WORDS) are ignored (aliasing).

## Configuration
- IMEM_LINE_RESPONDER_ERR_CHECK_EN
  - Defined: err=1 in IDLE for any of:
    - Rd and Wr both high;
    - misaligned access (Addr[0]=1 with Rd or Wr), which is not performed;
    - any X/Z on Addr, Rd, Wr, or DataIn (reduction-XOR === X test).
  - Undefined: err tied 0, and:
    - Rd and Wr both high is treated as a read;
    - Addr[0] is ignored.

## Test plan
- Reset, then Rd Addr=0x0010 with array[8]=0xBEEF:
  - Stall=1 cycles 0..8.
  - Done=1, CacheHit=0, DataOut=0xBEEF at cycle 9.
- Next cycle, Rd Addr=0x0012 (same line), array[9]=0x1234: Done=1, CacheHit=1, DataOut=0x1234 the same cycle.
- Wr Addr=0x0014, DataIn=0xA5A5 (buffered line):
  - Done=1, CacheHit=1.
  - Subsequent Rd 0x0014 hits and returns 0xA5A5.
  - A write to 0x0100 gives Done=1, CacheHit=0, and a later Rd 0x0100 misses.
- Rd miss Addr=0x0040; pull rst_n low at cycle 3:
  - All outputs 0 immediately.
  - After release, Rd 0x0040 misses again (full 9-cycle latency).
- With the macro defined:
  - Rd=Wr=1 gives err=1, Done=0, no array change.
  - Rd Addr=0x0011 gives err=1 and no fill.
- MISS_LAT=1: Rd miss gives Done exactly 6 cycles after accept; a back-to-back hit is accepted the cycle after RESP.
